// File: rtl/fm_iq_mod.sv
// fm_iq_mod: audio -> deviation-scaled phase accumulator -> pipelined CORDIC -> constant-envelope {Q,I}
// Define FM_IQ_MOD_PREEMPH_EN to add a first-order pre-emphasis stage ahead of the accumulator.
module fm_iq_mod #(
  parameter int PHASE_W = 32,
  parameter int STAGES  = 16,
  parameter int AMP     = 19898
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] audio,
  input  logic        audio_valid,
  output logic        audio_ready,
  input  logic [15:0] dev_gain,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int XW = 20;
  localparam logic signed [XW-1:0] X0  = XW'(AMP * 4);
  localparam logic signed [XW-1:0] LIM = XW'(32767);
  localparam logic [15:0] ATAN [16] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326,
                                        16'd163, 16'd81, 16'd41, 16'd20, 16'd10, 16'd5, 16'd3,
                                        16'd1, 16'd1, 16'd0};
  logic en, accept, src_v, a_v, fold;
  logic [15:0] src_a, src_g, theta;
  logic signed [31:0] prod;
  logic [PHASE_W-1:0] acc, inc;
  logic signed [XW-1:0] xs [STAGES], ys [STAGES], xn [STAGES], yn [STAGES];
  logic [15:0] zs [STAGES], zn [STAGES];
  logic [STAGES-1:0] vs;
  function automatic logic [15:0] sat_iq(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] s;
    s = v >>> 2;
    return s > LIM ? 16'h7fff : s < -LIM ? 16'h8001 : s[15:0];
  endfunction
  assign en = ~(out_valid & ~out_ready);
  assign audio_ready = en;
  assign accept = audio_valid & en;
`ifdef FM_IQ_MOD_PREEMPH_EN
  logic [15:0] prev, pre_a, pre_g;
  logic pre_v;
  logic signed [16:0] diff;
  assign diff = $signed({audio[15], audio}) - ($signed({prev[15], prev}) >>> 1);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      prev <= '0;
      pre_a <= '0;
      pre_g <= '0;
      pre_v <= 1'b0;
    end else if (en) begin
      prev <= accept ? audio : prev;
      pre_a <= diff[16] != diff[15] ? {diff[16], {15{~diff[16]}}} : diff[15:0];
      pre_g <= dev_gain;
      pre_v <= accept;
    end
  assign src_a = pre_a;
  assign src_g = pre_g;
  assign src_v = pre_v;
`else
  assign src_a = audio;
  assign src_g = dev_gain;
  assign src_v = accept;
`endif
  assign prod = $signed({{16{src_a[15]}}, src_a}) * $signed({16'd0, src_g});
  assign inc = PHASE_W'(prod);
  assign theta = acc[PHASE_W-1 -: 16];
  // Quadrants 1 and 2 start from -AMP so the CORDIC only ever rotates within +/-pi/2
  assign fold = theta[15] ^ theta[14];
  always_comb
    for (int i = 0; i < STAGES; i++) begin
      xn[i] = zs[i][15] ? xs[i] + (ys[i] >>> i) : xs[i] - (ys[i] >>> i);
      yn[i] = zs[i][15] ? ys[i] - (xs[i] >>> i) : ys[i] + (xs[i] >>> i);
      zn[i] = zs[i][15] ? zs[i] + ATAN[i] : zs[i] - ATAN[i];
    end
  // The last micro-rotation feeds the saturating output register directly
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      acc <= '0;
      a_v <= 1'b0;
      vs <= '0;
      out <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        zs[i] <= '0;
      end
    end else if (en) begin
      acc <= src_v ? acc + inc : acc;
      a_v <= src_v;
      xs[0] <= fold ? -X0 : X0;
      ys[0] <= '0;
      zs[0] <= {theta[15] ^ fold, theta[14:0]};
      for (int i = 1; i < STAGES; i++) begin
        xs[i] <= xn[i-1];
        ys[i] <= yn[i-1];
        zs[i] <= zn[i-1];
      end
      vs <= {vs[STAGES-2:0], a_v};
      out <= vs[STAGES-1] ? {sat_iq(yn[STAGES-1]), sat_iq(xn[STAGES-1])} : out;
      out_valid <= vs[STAGES-1];
    end
endmodule

// File: tb/tb_fm_iq_mod.sv
// tb_fm_iq_mod: directed vector table plus stall, reset, latency and random handshake sequences.
module tb_fm_iq_mod;
  localparam int STAGES = 16;
`ifdef FM_IQ_MOD_PREEMPH_EN
  localparam int LAT = STAGES + 3;
  localparam bit IDEAL = 1'b0;
  localparam int STEP_I = 27245, STEP_Q = 18204;
`else
  localparam int LAT = STAGES + 2;
  localparam bit IDEAL = 1'b1;
  localparam int STEP_I = 23170, STEP_Q = 23170;
`endif
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [15:0] audio = '0, dev_gain = '0;
  logic audio_valid = 1'b0, out_ready = 1'b1;
  logic audio_ready, out_valid;
  logic [31:0] out;

  fm_iq_mod dut (
    .aclk(aclk), .aresetn(aresetn), .audio(audio), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .dev_gain(dev_gain), .out(out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] m; int ei, eq, tol; bit id; } exp_t;
  typedef struct { logic [15:0] a, g; int ei, eq, tol; bit id; } vec_t;
  exp_t q[$];
  int nvec = 0, nerr = 0, n_acc = 0;
  int at [16];
  int cur_ei = 0, cur_eq = 0, cur_tol = 0;
  bit cur_id = 1'b0, held_v = 1'b0;
  logic [31:0] m_acc = '0, held = '0;
  logic [15:0] m_prev = '0;

  task automatic check(input string nm, input longint got, input longint want, input longint tol);
    nvec++;
    if (got > want + tol || got < want - tol) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (+/-%0d) at %0t", nm, got, want, tol, $time);
    end
  endtask

  function automatic int clip(input int v, input int lo, input int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

  function automatic int cosv(input int n);
    int c [5] = '{32767, 30273, 23170, 12539, 0};
    int m;
    m = ((n % 16) + 16) % 16;
    return m <= 4 ? c[m] : m <= 8 ? -c[8-m] : m <= 12 ? -c[m-8] : c[16-m];
  endfunction

  function automatic logic [31:0] model_iq(input logic [15:0] th);
    int x, y, z, t;
    bit f;
    f = th[15] ^ th[14];
    x = f ? -19898 * 4 : 19898 * 4;
    y = 0;
    z = int'($signed(f ? th ^ 16'h8000 : th));
    for (int i = 0; i < 16; i++) begin
      t = x;
      if (z >= 0) begin
        x = x - (y >>> i); y = y + (t >>> i); z = z - at[i];
      end else begin
        x = x + (y >>> i); y = y - (t >>> i); z = z + at[i];
      end
    end
    return {16'(clip(y >>> 2, -32767, 32767)), 16'(clip(x >>> 2, -32767, 32767))};
  endfunction

  task automatic model_accept(input logic [15:0] a_in, input logic [15:0] g);
    logic signed [15:0] a;
    exp_t e;
    a = a_in;
`ifdef FM_IQ_MOD_PREEMPH_EN
    a = 16'(clip(int'($signed(a_in)) - (int'($signed(m_prev)) >>> 1), -32768, 32767));
    m_prev = a_in;
`endif
    m_acc = m_acc + 32'(int'(a) * int'({16'h0, g}));
    e.m = model_iq(m_acc[31:16]);
    e.ei = cur_ei; e.eq = cur_eq; e.tol = cur_tol; e.id = cur_id;
    q.push_back(e);
  endtask

  // Handshakes and outputs are observed mid-cycle, when inputs and registered outputs are settled
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      q.delete();
      m_acc = '0;
      m_prev = '0;
      held_v = 1'b0;
    end else begin
      check("audio_ready", audio_ready, !(out_valid && !out_ready), 0);
      if (held_v) begin
        check("stall_hold_out", out, held, 0);
        check("stall_hold_valid", out_valid, 1, 0);
      end
      held_v = out_valid && !out_ready;
      held = out;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL out_extra: got output %h, required none pending", out);
        end else begin
          e = q.pop_front();
          check("out_model", out, e.m, 0);
          if (e.id) begin
            check("out_I", $signed(out[15:0]), e.ei, e.tol);
            check("out_Q", $signed(out[31:16]), e.eq, e.tol);
          end
        end
      end
      if (audio_valid && audio_ready) begin
        model_accept(audio, dev_gain);
        n_acc++;
      end
    end
  end

  task automatic beat(input logic [15:0] a, input logic [15:0] g, input int ei, input int eq,
                      input int tol, input bit id);
    int n = 0;
    audio = a; dev_gain = g; audio_valid = 1'b1;
    cur_ei = ei; cur_eq = eq; cur_tol = tol; cur_id = id;
    @(negedge aclk);
    while (!audio_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) begin
      nvec++; nerr++;
      $display("FAIL beat_accept: audio_ready stayed 0, required 1");
    end
    @(posedge aclk); #1;
    audio_valid = 1'b0;
    cur_id = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    audio_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0, 0);
    repeat (3) begin @(posedge aclk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    int n, start, cyc;
    for (int i = 0; i < 16; i++)
      at[i] = $rtoi($atan(1.0 / real'(1 << i)) * 65536.0 / (2.0 * 3.141592653589793) + 0.5);
    for (int i = 0; i < 8; i++) tv.push_back('{16'd12345, 16'd0, 32767, 0, 8, 1'b1});
    for (int i = 1; i <= 33; i++)
      tv.push_back('{16'd16384, 16'd16384, cosv(i), cosv(i - 4), 16, IDEAL});

    repeat (3) @(posedge aclk);
    #1;
    check("reset_out_valid", out_valid, 0, 0);
    check("reset_out", out, 0, 0);
    check("reset_audio_ready", audio_ready, 1, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    foreach (tv[i]) beat(tv[i].a, tv[i].g, tv[i].ei, tv[i].eq, tv[i].tol, tv[i].id);
    drain();

    beat(16'd16384, 16'd16384, 0, 0, 0, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge aclk); #1;
      n++;
    end
    check("latency", n + 1, LAT, 0);
    drain();

    for (int i = 0; i < 30; i++) begin
      if (i == 22) begin
        audio = 16'd16384; dev_gain = 16'd16384; audio_valid = 1'b1; out_ready = 1'b0;
        repeat (5) begin @(posedge aclk); #1; end
        out_ready = 1'b1;
      end
      beat(16'd16384, 16'd16384, 0, 0, 0, 1'b0);
    end
    drain();

    for (int i = 0; i < 25; i++) beat(16'd16384, 16'd16384, 0, 0, 0, 1'b0);
    aresetn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0, 0);
    check("midrst_out", out, 0, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    beat(16'd16384, 16'd16384, 30273, 12539, 16, 1'b1);
    beat(16'd16384, 16'd16384, STEP_I, STEP_Q, 16, 1'b1);
    drain();

    start = n_acc;
    cyc = 0;
    while (n_acc - start < 2000 && cyc < 20000) begin
      audio = 16'($urandom);
      dev_gain = 16'($urandom);
      audio_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge aclk); #1;
      cyc++;
    end
    check("random_beats", n_acc - start, 2000, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
